// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bundle: icache request/response, decoder hookup, IQ head and commit redirect.
// Latency: none, wires only.
// Backpressure: none here; the controller throttles requests on IQ occupancy.
interface inst_fetch_ctrl_if;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_inst;
    logic [31:0] dec_inst;
    logic        dec_jump;
    logic [31:0] dec_imm;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_pop;
    logic        flush_in;
    logic [31:0] flush_pc;

    // Fetch controller side
    modport master (
        output icache_req_valid, icache_req_addr, dec_inst, iq_valid, iq_inst, iq_pc,
        input  icache_resp_valid, icache_resp_inst, dec_jump, dec_imm, iq_pop, flush_in, flush_pc
    );

    // Environment side: icache, decoder, dispatch and commit
    modport slave (
        input  icache_req_valid, icache_req_addr, dec_inst, iq_valid, iq_inst, iq_pc,
        output icache_resp_valid, icache_resp_inst, dec_jump, dec_imm, iq_pop, flush_in, flush_pc
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one icache request at a time, queues {pc, inst}.
// Latency: request registered 1 cycle after IDLE; IQ entry visible the cycle after the response.
// Backpressure: no request while the IQ is full; rdy_in low freezes everything and masks the request.
module inst_fetch_ctrl #(
    parameter int unsigned IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    inst_fetch_ctrl_if.master bus
);
    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // IDLE: free to request; WAIT: live request out; DROP: request out but its word is stale
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP} state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               req_vld_q, req_vld_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        iq_pc_q   [IQ_DEPTH];
    logic [31:0]        iq_inst_q [IQ_DEPTH];
    logic               push, pop;

    // Next-state, PC, request and IQ pointer logic; flush wins over push/pop/issue
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_vld_d  = req_vld_q;
        req_addr_d = req_addr_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        push       = 1'b0;
        pop        = 1'b0;
        if (rdy_in) begin
            req_vld_d = 1'b0;
            if (bus.flush_in) begin
                pc_d    = bus.flush_pc;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                case (state_q)
                    ST_WAIT, ST_DROP: state_d = bus.icache_resp_valid ? ST_IDLE : ST_DROP;
                    default:          state_d = ST_IDLE;
                endcase
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (count_q < CNT_W'(IQ_DEPTH)) begin
                            req_vld_d  = 1'b1;
                            req_addr_d = pc_q;
                            state_d    = ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (bus.icache_resp_valid) begin
                            push    = 1'b1;
                            // Only JAL is predicted; everything else falls through
                            pc_d    = bus.dec_jump ? (pc_q + bus.dec_imm) : (pc_q + 32'd4);
                            state_d = ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (bus.icache_resp_valid) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
                pop = bus.iq_pop && (count_q != '0);
                if (push) begin
                    tail_d = tail_q + PTR_W'(1);
                end
                if (pop) begin
                    head_d = head_q + PTR_W'(1);
                end
                count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_vld_q  <= 1'b0;
            req_addr_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_vld_q  <= req_vld_d;
            req_addr_q <= req_addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // IQ storage: write the fetched pair at the tail; contents need no reset since count gates use
    always_ff @(posedge clk_in) begin
        if (!rst_in && push) begin
            iq_pc_q[tail_q]   <= pc_q;
            iq_inst_q[tail_q] <= bus.icache_resp_inst;
        end
    end

    // A request held across a freeze is only presented once rdy_in returns
    assign bus.icache_req_valid = req_vld_q & rdy_in;
    assign bus.icache_req_addr  = req_addr_q;
    assign bus.dec_inst         = bus.icache_resp_inst;
    assign bus.iq_valid         = (count_q != '0);
    assign bus.iq_pc            = iq_pc_q[head_q];
    assign bus.iq_inst          = iq_inst_q[head_q];
endmodule
